la_sram_reader: RTL and testbench
=================================

Name: la_sram_reader

Overview:
- Reads a logic-analyzer capture back out of the two quad-SPI sample SRAMs after the capture engine has filled them.
- Chip 0 holds lat[3:0] on sio[3:0]; chip 1 holds lat[7:4] on sio[7:4]. One SRAM clock returns one 8-bit sample.
- Both chips get the same SQI READ sequence in lock-step, and the read is paced by the consumer through a ready/valid stream.
- Sits between the top-level SRAM pin muxes and the MCU register bank, which drains samples into a read register.

Parameters:
- LA_WIDTH, 8, sample width; two nibble-wide chips.
- ADDR_WIDTH, 24, SRAM address field width sent on the bus.
- CNT_WIDTH, 23, sample-count width; matches the capture sample counter.
- DUMMY_NIBBLES, 2, SQI dummy clocks between address and data.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a read when idle.
- abort  in  1  one-cycle pulse; cancels the read.
- start_addr  in  ADDR_WIDTH  first sample address.
- sample_count  in  CNT_WIDTH  number of samples to read.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the final sample has been accepted.
- sample_data  out  LA_WIDTH  head of the FIFO.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts sample_data.
- sram_sclk  out  1  SRAM clock for both chips.
- sram_cs_n  out  2  chip selects, active low; both bits always equal.
- sio_oe  out  1  drive enable for all 8 sio pins.
- sio_dout  out  LA_WIDTH  data to the pins; the same nibble is placed on both halves.
- sio_din  in  LA_WIDTH  data from the pins.

Behaviour:
- Reset values:
  - busy=0, done=0, sample_valid=0, sample_data=0.
  - sram_sclk=0, sram_cs_n=2'b11, sio_oe=0, sio_dout=0.
  - FIFO empty.
- Bit timing:
  - sram_sclk toggles every clock while running, so SPI rate is clock/2.
  - A nibble is driven in the cycle where sclk is low.
  - sio_din is captured at the clock edge that ends a high phase, i.e. the SRAM's rising-edge-valid window.
- States:
  - IDLE: waits for start. On start with sample_count==0, pulse done the next cycle, leave CS high, do nothing else. On start with sample_count>0, latch addr and count, go to CMD.
  - CMD: 2 nibbles of 8'h03 (READ), MSB nibble first, sio_oe=1.
  - ADDR: 6 nibbles of start_addr, MSB first, sio_oe=1.
  - DUMMY: DUMMY_NIBBLES clocks, sio_oe=0 from the first dummy low phase (bus turnaround).
  - DATA: each high phase captures {chip1 nibble, chip0 nibble} = sio_din[7:0] into the FIFO and decrements the remaining count. At 0, go to FINISH.
  - FINISH: sclk=0, CS high; wait until the FIFO is empty, then pulse done and return to IDLE.
- Timing of a read:
  - CS goes low in the cycle after start.
  - With sample_ready held at 1, the first sample_valid is asserted exactly 23 clocks after the start cycle. That is 10 overhead nibbles × 2 clocks plus capture and write.
  - After that, one sample arrives per 2 clocks.
- Back-pressure:
  - A new high phase may start only when the FIFO has at least 1 free entry counting the in-flight capture.
  - Otherwise sclk holds low and CS stays low; SRAM SQI reads tolerate the clock stopping.
  - No sample is ever dropped or duplicated.
- Address wrap: the SRAM auto-increments and wraps internally; the block never re-issues an address.
- FIFO:
  - First-word fall-through.
  - Pop on sample_valid && sample_ready.
  - A simultaneous push and pop when full is not possible because of the stall rule.
  - A simultaneous push and pop when empty-plus-one keeps the count unchanged.
- start while busy is ignored.
- abort:
  - Next cycle: CS high, sclk=0, sio_oe=0, FIFO flushed, state IDLE.
  - No done pulse.
  - abort has priority over start in the same cycle.
- Asynchronous reset mid-operation forces all reset values immediately; no partial done.

Decomposition:
- Package la_pkg: SRAM_CMD_READ=8'h03, SRAM_CMD_WRITE=8'h02, the nibble counts for the CMD and ADDR phases, and the state enum type.
- Sub-module la_sample_fifo: parameterised FWFT FIFO with push, pop, flush, empty, full and a count output.

Test Plan:
- start_addr=24'h000010, sample_count=4, sio_din sequence 8'hA5,8'h3C,8'h00,8'hFF, ready=1:
  - sio_dout high nibbles in order: 0,3,0,0,0,0,1,0.
  - sio_oe falls on the first dummy low phase.
  - Samples A5,3C,00,FF are output in order.
  - done pulses once; first valid arrives at cycle 23.
- sample_count=8, sample_ready=0 for 20 cycles then 1:
  - sclk stalls low with exactly FIFO_DEPTH entries held.
  - CS stays low throughout the stall.
  - All 8 samples are delivered in order.
- sample_count=0 start: done pulses 1 cycle later; CS never goes low; no sample_valid.
- abort asserted on the 3rd DATA sample, sample_count=100:
  - Next cycle: CS=2'b11, sample_valid=0, busy=0.
  - No done pulse.
  - A subsequent start works normally.
- reset asserted mid-ADDR:
  - Outputs return to reset values in the same cycle, without waiting for a clock edge.
  - After reset is released, a fresh read matches the first scenario.
- start pulsed again while busy: ignored; the transaction and its sample stream are unchanged.

Source files
------------

// File: rtl/la_pkg.sv
// Shared constants and state type for the logic-analyzer SRAM readback path.
// Both sample chips are quad-SPI SRAMs driven in lock-step.
package la_pkg;

    localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
    localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;

    localparam int CMD_NIBBLES  = 2;
    localparam int ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_FINISH
    } la_state_t;

endpackage

// File: rtl/la_sample_fifo.sv
// First-word fall-through sample buffer between the SRAM capture and the MCU drain.
// DEPTH must be a power of two so the pointers wrap naturally.
module la_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/la_sram_reader.sv
// Streams a capture back out of the two nibble-wide SQI sample SRAMs.
// One SQI READ is issued to both chips; each SRAM clock yields one 8-bit sample.
module la_sram_reader
    import la_pkg::*;
#(
    parameter int LA_WIDTH      = 8,
    parameter int ADDR_WIDTH    = 24,
    parameter int CNT_WIDTH     = 23,
    parameter int DUMMY_NIBBLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  sample_count,
    output logic                  busy,
    output logic                  done,
    output logic [LA_WIDTH-1:0]   sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sram_sclk,
    output logic [1:0]            sram_cs_n,
    output logic                  sio_oe,
    output logic [LA_WIDTH-1:0]   sio_dout,
    input  logic [LA_WIDTH-1:0]   sio_din
);

    localparam int SHIFT_W = 8 + ADDR_WIDTH;
    localparam int CW      = $clog2(FIFO_DEPTH);

    la_state_t            state, state_nx;
    logic                 sclk, sclk_nx;
    logic [7:0]           nib_cnt, nib_cnt_nx;
    logic [SHIFT_W-1:0]   shift, shift_nx;
    logic [CNT_WIDTH-1:0] remaining, remaining_nx;

    logic [7:0]           phase_last;
    la_state_t            phase_next;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CW:0]          fifo_count;

    la_sample_fifo #(
        .WIDTH (LA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (sio_din),
        .pop       (pop),
        .flush     (abort),
        .head      (sample_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sclk      <= 1'b0;
            nib_cnt   <= '0;
            shift     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            sclk      <= sclk_nx;
            nib_cnt   <= nib_cnt_nx;
            shift     <= shift_nx;
            remaining <= remaining_nx;
        end
    end

    // Length and successor of the current preamble phase.
    always_comb begin
        phase_last = 8'(DUMMY_NIBBLES - 1);
        phase_next = ST_DATA;
        case (state)
            ST_CMD: begin
                phase_last = 8'(CMD_NIBBLES - 1);
                phase_next = ST_ADDR;
            end
            ST_ADDR: begin
                phase_last = 8'(ADDR_NIBBLES - 1);
                phase_next = ST_DUMMY;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state;
        sclk_nx      = sclk;
        nib_cnt_nx   = nib_cnt;
        shift_nx     = shift;
        remaining_nx = remaining;
        push         = 1'b0;
        if (abort) begin
            state_nx   = ST_IDLE;
            sclk_nx    = 1'b0;
            nib_cnt_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sclk_nx    = 1'b0;
                        nib_cnt_nx = '0;
                        if (sample_count == '0) begin
                            state_nx = ST_FINISH;
                        end else begin
                            state_nx     = ST_CMD;
                            shift_nx     = {SRAM_CMD_READ, start_addr};
                            remaining_nx = sample_count;
                        end
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY: begin
                    sclk_nx = !sclk;
                    // A nibble ends with its high phase; advance on that edge.
                    if (sclk) begin
                        shift_nx   = shift << 4;
                        nib_cnt_nx = nib_cnt + 8'd1;
                        if (nib_cnt == phase_last) begin
                            nib_cnt_nx = '0;
                            state_nx   = phase_next;
                        end
                    end
                end
                ST_DATA: begin
                    if (!sclk) begin
                        // Hold the clock low until the capture has a slot to land in.
                        if (!fifo_full) sclk_nx = 1'b1;
                    end else begin
                        sclk_nx      = 1'b0;
                        push         = 1'b1;
                        remaining_nx = remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) state_nx = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (fifo_count == '0) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FINISH) && (fifo_count == '0) && !abort;
    assign sample_valid = !fifo_empty;
    assign pop          = sample_valid && sample_ready;

    assign sram_sclk = sclk;
    assign sram_cs_n = (state == ST_CMD || state == ST_ADDR ||
                        state == ST_DUMMY || state == ST_DATA) ? 2'b00 : 2'b11;
    assign sio_oe    = (state == ST_CMD || state == ST_ADDR);
    // Both chips take the same command/address nibble.
    assign sio_dout  = sio_oe ? {2{shift[SHIFT_W-1 -: 4]}} : '0;

endmodule

// File: tb/tb_la_sram_reader.sv
// Scoreboard bench: a behavioural SRAM pair feeds random samples and records the
// command/address it sees; a monitor checks every accepted sample in order.
module tb_la_sram_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] start_addr = '0;
    logic [22:0] sample_count = '0;
    logic        busy, done, sample_valid, sample_ready;
    logic [7:0]  sample_data;
    logic        sram_sclk, sio_oe;
    logic [1:0]  sram_cs_n;
    logic [7:0]  sio_dout;
    logic [7:0]  sio_din = '0;

    int tests = 0, fails = 0, cyc = 0;
    logic rnd_mode = 1'b0, rnd_bit = 1'b0, ready_force = 1'b1;
    assign sample_ready = rnd_mode ? rnd_bit : ready_force;

    logic [7:0]  exp_q[$];
    logic [7:0]  forced_q[$];
    logic [23:0] addr_q[$];
    int          rises = 0, issued = 0, done_cnt = 0, first_cyc = 0, start_cyc = 0;
    bit          first_seen = 0, cs_low_seen = 0;
    logic [31:0] cmdaddr = '0;

    la_sram_reader dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .start_addr(start_addr), .sample_count(sample_count),
        .busy(busy), .done(done), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sram_sclk(sram_sclk), .sram_cs_n(sram_cs_n), .sio_oe(sio_oe),
        .sio_dout(sio_dout), .sio_din(sio_din)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial forever begin
        @(posedge clock);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // SRAM pair model: 2 cmd + 6 addr + 2 dummy clocks, then one sample per clock.
    always @(negedge sram_cs_n[0]) begin
        rises   = 0;
        issued  = 0;
        cmdaddr = '0;
    end

    always @(posedge sram_sclk) begin
        logic [7:0] v;
        if (sram_cs_n == 2'b00) begin
            rises++;
            if (rises <= 8) begin
                check("oe_cmd_addr", sio_oe, 1'b1);
                check("dout_halves", sio_dout[3:0], sio_dout[7:4]);
                cmdaddr = {cmdaddr[27:0], sio_dout[7:4]};
            end else if (rises <= 10) begin
                check("oe_dummy", sio_oe, 1'b0);
            end else begin
                v = (forced_q.size() > 0) ? forced_q.pop_front() : 8'($urandom);
                sio_din = v;
                exp_q.push_back(v);
                issued++;
            end
        end
    end

    always @(posedge sram_cs_n[0]) begin
        logic [23:0] a;
        if (addr_q.size() > 0) begin
            a = addr_q.pop_front();
            if (rises >= 8) check("cmd_addr", cmdaddr, {8'h03, a});
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (sram_cs_n != 2'b11) cs_low_seen = 1;
            if (done) done_cnt++;
            if (sample_valid && !first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) check("unexpected_sample", sample_data, 32'hFFFF_FFFF);
                else check("sample", sample_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_start(input logic [23:0] a, input logic [22:0] n);
        start_addr   = a;
        sample_count = n;
        start        = 1'b1;
        first_seen   = 0;
        start_cyc    = cyc;
        if (n != 0) addr_q.push_back(a);
        tick();
        start = 1'b0;
    endtask

    task automatic stray_start(input logic [23:0] a, input logic [22:0] n);
        start_addr   = a;
        sample_count = n;
        start        = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || sample_valid) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {busy, sample_valid}, 2'b00);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_valid"}, sample_valid, 1'b0);
        check({tag, "_data"},  sample_data, 8'h00);
        check({tag, "_sclk"},  sram_sclk, 1'b0);
        check({tag, "_cs"},    sram_cs_n, 2'b11);
        check({tag, "_oe"},    sio_oe, 1'b0);
        check({tag, "_dout"},  sio_dout, 8'h00);
    endtask

    task automatic run_fixed(input string tag);
        int d0 = done_cnt;
        forced_q    = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        ready_force = 1'b1;
        rnd_mode    = 1'b0;
        do_start(24'h000010, 23'd4);
        wait_idle(200, tag);
        check({tag, "_latency"}, first_cyc - start_cyc, 23);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0, n;
        #3;
        check_reset_vals("por");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        run_fixed("basic");

        // Back-pressure: consumer stalls, the SRAM clock must park with a full buffer.
        ready_force = 1'b0;
        d0 = done_cnt;
        do_start(24'($urandom), 23'd8);
        n = 0;
        while (!sample_valid && n < 60) begin tick(); n++; end
        check("stall_first_valid", sample_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 10) begin
                check("stall_sclk", sram_sclk, 1'b0);
                check("stall_cs", sram_cs_n, 2'b00);
            end
        end
        check("stall_held", issued, 4);
        ready_force = 1'b1;
        wait_idle(200, "stall");
        check("stall_done", done_cnt - d0, 1);
        check("stall_drained", exp_q.size(), 0);

        // Zero-length read.
        d0 = done_cnt;
        cs_low_seen = 0;
        do_start(24'h0000AA, 23'd0);
        check("zero_done_next", done, 1'b1);
        repeat (10) tick();
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_no_cs", cs_low_seen, 1'b0);
        check("zero_no_valid", first_seen, 1'b0);

        // Abort during the third data sample.
        ready_force = 1'b0;
        d0 = done_cnt;
        do_start(24'($urandom), 23'd100);
        n = 0;
        while (issued < 3 && n < 80) begin tick(); n++; end
        check("abort_reach", issued, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cs", sram_cs_n, 2'b11);
        check("abort_valid", sample_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_sclk_oe", {sram_sclk, sio_oe}, 2'b00);
        exp_q.delete();
        repeat (5) tick();
        check("abort_no_done", done_cnt - d0, 0);
        rnd_mode = 1'b1;
        do_start(24'($urandom), 23'd5);
        wait_idle(300, "after_abort");
        rnd_mode = 1'b0;
        check("after_abort_done", done_cnt - d0, 1);
        check("after_abort_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of the address phase.
        ready_force = 1'b1;
        forced_q.delete();
        do_start(24'h000010, 23'd4);
        n = 0;
        while (rises < 4 && n < 40) begin tick(); n++; end
        check("reset_reach_addr", rises, 4);
        #2 reset = 1'b1;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        run_fixed("post_reset");

        // Start pulses while busy must not disturb the transaction.
        d0 = done_cnt;
        do_start(24'($urandom), 23'd6);
        repeat (6) tick();
        stray_start(24'h123456, 23'd3);
        n = 0;
        while (issued < 2 && n < 60) begin tick(); n++; end
        stray_start(24'h654321, 23'd9);
        wait_idle(200, "rebusy");
        check("rebusy_done", done_cnt - d0, 1);
        check("rebusy_drained", exp_q.size(), 0);

        // Random reads with a random consumer.
        for (int t = 0; t < 6; t++) begin
            d0 = done_cnt;
            rnd_mode = 1'b1;
            do_start(24'($urandom), 23'($urandom_range(1, 12)));
            wait_idle(400, "rand");
            check("rand_done", done_cnt - d0, 1);
            check("rand_drained", exp_q.size(), 0);
        end
        rnd_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
